unpad_stream: RTL

- Inverse of the convolution front-end padder.
- Accepts a raster-order stream of a padded (D+2*PAD) x (D+2*PAD) frame and forwards only the D x D interior pixels; border pixels are dropped.
- Sits after a convolution or pooling stage, or at a loopback check point, to recover the unpadded feature map.
- Pure streaming: row/column counters, no frame memory, registered output with 1-cycle latency.

---
 rtl/unpad_stream_pkg.sv | 15 +
 rtl/raster_counter.sv | 42 ++++
 rtl/unpad_stream.sv | 105 ++++++++++
 3 files changed

// File: rtl/unpad_stream_pkg.sv
// Shared types and helpers for the unpad / pad raster-stream blocks.
// Holds the frame FSM encoding and the padded-dimension derivation.
package unpad_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int padded_dim(input int d, input int pad);
        return d + 2 * pad;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster col/row position counter for a DP x DP frame; advances one pixel per cycle.
// clear makes the current pixel read as (0,0) so a frame can restart without a bubble.
module raster_counter #(
    parameter int DP = 6,
    parameter int CW = (DP > 1) ? $clog2(DP) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    input  logic          clear,
    output logic [CW-1:0] col,
    output logic [CW-1:0] row,
    output logic          col_wrap,
    output logic          frame_wrap
);

    localparam logic [CW-1:0] LAST = CW'(DP - 1);

    logic [CW-1:0] col_q;
    logic [CW-1:0] row_q;

    // Position of the pixel presented this cycle; clear overrides the stored count.
    assign col        = clear ? '0 : col_q;
    assign row        = clear ? '0 : row_q;
    assign col_wrap   = (col == LAST);
    assign frame_wrap = col_wrap && (row == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (advance) begin
            col_q <= col_wrap ? '0 : col + CW'(1);
            if (col_wrap) begin
                row_q <= frame_wrap ? '0 : row + CW'(1);
            end else begin
                row_q <= row;
            end
        end
    end

endmodule

// File: rtl/unpad_stream.sv
// Strips a PAD-wide border from a raster (D+2*PAD)^2 stream, forwarding the D x D interior with 1-cycle latency.
// Optional eof output marking the last interior pixel is enabled by defining UNPAD_FRAME_END_EN.
module unpad_stream
    import unpad_stream_pkg::*;
#(
    parameter int D          = 220,
    parameter int PAD        = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  sof,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid,
    output logic                  busy
`ifdef UNPAD_FRAME_END_EN
    ,
    output logic                  eof
`endif
);

    localparam int DP = padded_dim(D, PAD);
    localparam int CW = (DP > 1) ? $clog2(DP) : 1;
    localparam logic [CW-1:0] LO = CW'(PAD);
    localparam logic [CW-1:0] HI = CW'(PAD + D - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          col_wrap;
    logic          frame_wrap;
    logic          new_frame;
    logic          interior;

    // Outside RUN every accepted pixel opens a frame, so sof is only needed to abort.
    assign new_frame = sof || (state != RUN);

    raster_counter #(
        .DP (DP),
        .CW (CW)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .advance    (en),
        .clear      (new_frame),
        .col        (col),
        .row        (row),
        .col_wrap   (col_wrap),
        .frame_wrap (frame_wrap)
    );

    assign interior = (col >= LO) && (col <= HI) && (row >= LO) && (row <= HI);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en) state_nxt = RUN;
            end
            RUN: begin
                if (en && frame_wrap) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = en ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pxl_out <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= en && interior;
            if (en && interior) begin
                pxl_out <= pxl_in;
            end
        end
    end

`ifdef UNPAD_FRAME_END_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eof <= 1'b0;
        end else begin
            eof <= en && interior && (col == HI) && (row == HI);
        end
    end
`endif

endmodule
